// File: rtl/cpu_out_fifo.sv
// Output buffer between the CPU's FPGAOut path and a board-side consumer.
// Words are drained over valid/ready, and a sticky overflow flag records any dropped write.
module cpu_out_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             overflow,
  input  logic             clr_ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             push;
  logic             pop;

  // Status is decoded only from the registered count, so there is no wr_data-to-output path.
  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = wr_en & (~full | pop);
  assign out_data  = mem[rdPtr];

  // Storage is deliberately left out of reset; stale words are hidden by out_valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wrPtr] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + AW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A dropped write wins over a clear arriving in the same cycle.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (wr_en && full && !pop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_out_fifo.sv
// Scoreboard bench for cpu_out_fifo: stimulus pushes accepted words, a negedge monitor checks the head.
// A queue-based reference model predicts acceptance, occupancy and the overflow flag.
module tb_cpu_out_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             reset;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             full;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             clr_ovf;

  logic [WIDTH-1:0] refQ[$];
  logic [WIDTH-1:0] expQ[$];
  logic             refOvf = 1'b0;
  int               checkCount = 0;
  int               passCount = 0;

  cpu_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  always #15 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
  endtask

  // Called just after a rising edge; drives one cycle of inputs and advances the model across the next edge.
  task automatic applyStimulus(input logic we, input logic [WIDTH-1:0] d, input logic rdy, input logic clr);
    int   refCnt;
    logic modelPop;
    logic modelPush;
    wr_en = we; wr_data = d; out_ready = rdy; clr_ovf = clr;
    refCnt    = refQ.size();
    modelPop  = (refCnt > 0) && rdy;
    modelPush = we && ((refCnt < DEPTH) || modelPop);
    @(negedge CLK);
    checkOutput("count", 32'(count), 32'(refCnt));
    checkOutput("out_valid", 32'(out_valid), 32'(refCnt != 0));
    checkOutput("full", 32'(full), 32'(refCnt == DEPTH));
    checkOutput("overflow", 32'(overflow), 32'(refOvf));
    @(posedge CLK);
    #1;
    if (modelPop) void'(refQ.pop_front());
    if (modelPush) begin
      refQ.push_back(d);
      expQ.push_back(d);
    end
    if (we && (refCnt == DEPTH) && !modelPop) refOvf = 1'b1;
    else if (clr) refOvf = 1'b0;
  endtask

  // Monitor: the head must always equal the oldest accepted word; it is consumed when accepted.
  always @(negedge CLK) begin
    if (reset && out_valid) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL head: got %0h, expected no valid word at %0t", out_data, $time);
      end else begin
        checkOutput("head", 32'(out_data), 32'(expQ[0]));
        if (out_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b0; wr_en = 1'b0; wr_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    #200;
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("rel_count", 32'(count), 32'd0);
    checkOutput("rel_valid", 32'(out_valid), 32'd0);
    @(posedge CLK);
    #1;

    $display("[TB] single word");
    applyStimulus(1'b1, 16'h0009, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    $display("[TB] fill and overflow");
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h00FF, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    $display("[TB] simultaneous push and pop at full");
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0600, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    $display("[TB] wrap-around streaming");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 16'hC000 + 16'(i), 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 3) != 0, 16'($urandom), ($urandom % 2) == 1, ($urandom % 8) == 0);
    end
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
    #5;
    reset = 1'b0;
    #1;
    checkOutput("midrst_count", 32'(count), 32'd0);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    refQ.delete();
    expQ.delete();
    refOvf = 1'b0;
    wr_en = 1'b0;
    #10;
    reset = 1'b1;
    @(posedge CLK);
    #1;
    applyStimulus(1'b1, 16'h0C00, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);

    checkOutput("drained", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/cpu_out_fifo.md
Name: cpu_out_fifo

Overview:
Buffers 16-bit words written by the integration3 CPU to its FPGAOut port and drains them to a downstream board-side consumer over a valid/ready handshake. It sits directly downstream of the CPU's output path. The CPU can execute several back-to-back output instructions without stalling on a slow consumer, such as a display or serial driver. A sticky overflow flag records any dropped word so the test bench can detect data loss.

Parameters:
WIDTH, 16, data word width; matches the CPU datapath.
DEPTH, 8, number of entries; power of two, 2..256.
CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
CLK  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
wr_en  input  1  CPU output-instruction strobe; one word is offered per cycle it is high.
wr_data  input  WIDTH  word from the CPU FPGAOut path.
full  output  1  high when count == DEPTH.
out_valid  output  1  head word is available; equals (count != 0).
out_ready  input  1  consumer accepts the head word this cycle.
out_data  output  WIDTH  head word; mem[rd_ptr].
count  output  CW  current occupancy, 0..DEPTH.
overflow  output  1  sticky flag: set when a write is dropped.
clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset == 0, asynchronous): wr_ptr = 0, rd_ptr = 0, count = 0, overflow = 0.
  - Resulting outputs: full = 0, out_valid = 0.
  - out_data is don't-care while out_valid = 0; storage contents are not cleared.
- Reset asserted mid-operation discards all queued words immediately, without waiting for a clock edge.
- Push condition: push = wr_en & (~full | pop).
- Pop condition: pop = out_valid & out_ready.
- On push: mem[wr_ptr] <= wr_data, then wr_ptr increments modulo DEPTH.
- On pop: rd_ptr increments modulo DEPTH.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push and pop together, or on neither.
- Latency:
  - A word written at edge N into an empty FIFO gives out_valid = 1 and out_data = that word after edge N.
  - There is no combinational path from wr_data to out_data.
- Handshake rules:
  - out_data and out_valid are held stable while out_valid = 1 and out_ready = 0.
  - out_ready while empty has no effect; the count never underflows.
- Full boundary:
  - wr_en with full = 1 and no pop: the word is dropped, state is unchanged, and overflow <= 1.
  - wr_en with full = 1 and pop in the same cycle: the write is accepted, count stays at DEPTH, and overflow is not set.
- Empty boundary: wr_en and out_ready together while empty is a push only; the count goes 0 -> 1 and nothing is popped that cycle.
- Pointer wrap: pointers roll over from DEPTH-1 to 0; FIFO ordering is preserved across the wrap.
- overflow priority:
  - Set has priority over clr_ovf in the same cycle.
  - Otherwise clr_ovf = 1 forces overflow to 0.
- Control signals (full, out_valid, count) are registered, or decoded only from registered count.

Test Plan:
- Reset: hold reset = 0 for 200 ns with CLK at a 30 ns period.
  - Required: count = 0, out_valid = 0, full = 0, overflow = 0.
  - Then release reset and verify these outputs are still 0.
- Single word: push 16'h0009 with out_ready = 0.
  - Required: after the edge, out_valid = 1, out_data = 16'h0009, count = 1.
  - Hold out_ready = 0 for 3 cycles: out_data must remain 16'h0009.
  - Assert out_ready for 1 cycle: count returns to 0.
- Fill and overflow: push 0x0001..0x0008 with out_ready = 0, then push 0x00FF.
  - Required: full = 1, count = 8, overflow = 1.
  - Draining must yield 0x0001..0x0008 in order; 0x00FF must never appear.
  - Pulse clr_ovf: overflow must go to 0.
- Simultaneous at full: with the FIFO full of 0x0001..0x0008, assert wr_en = 1 (wr_data = 0x0600) and out_ready = 1 for one cycle.
  - Required: count stays 8, overflow stays 0.
  - Drain order must be 0x0002..0x0008, then 0x0600.
- Wrap-around: stream 20 words 0xC000 + i (i = 0..19) with wr_en and out_ready both held high.
  - Required: the consumer receives all 20 words in order.
  - count stays at 1 after the first push, and the pointers wrap twice.
- Reset mid-stream: with 5 words queued, pull reset low between clock edges.
  - Required: count = 0 and out_valid = 0 immediately, without waiting for an edge.
  - After release, the next push of 16'h0C00 must appear as the head word.
